// File: rtl/filter_arbiter_pkg.sv
// Shared MD constants: default widths, filter count and the field layout of
// one packed pair word {r2, dz, dy, dx}.
package filter_arbiter_pkg;

  localparam int MD_DATA_WIDTH      = 32;
  localparam int MD_NUM_FILTER      = 8;
  localparam int MD_FILTER_ID_WIDTH = 3;
  localparam int MD_FIELDS_PER_PAIR = 4;

  // Field position inside a pair word, dx in the least significant slot.
  typedef enum int {
    FIELD_DX = 0,
    FIELD_DY = 1,
    FIELD_DZ = 2,
    FIELD_R2 = 3
  } md_field_e;

  // Bit offset of a field inside a pair word.
  function automatic int field_lsb(md_field_e f, int data_width);
    return int'(f) * data_width;
  endfunction

endpackage

// File: rtl/filter_arbiter_rr_select.sv
// Round-robin selector: picks the first requesting index after last_grant,
// wrapping from NUM_FILTER-1 back to 0.
module rr_select #(
  parameter int NUM_FILTER      = 8,
  parameter int FILTER_ID_WIDTH = 3
) (
  input  logic [NUM_FILTER-1:0]      req,
  input  logic [FILTER_ID_WIDTH-1:0] last_grant,
  output logic                       gnt_valid,
  output logic [FILTER_ID_WIDTH-1:0] gnt_idx
);

  // Walk the rotated request vector from farthest to nearest so the
  // closest requester after last_grant is the one left standing.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_FILTER; k >= 1; k--) begin
      int cand;
      cand = (int'(last_grant) + k) % NUM_FILTER;
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = FILTER_ID_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/filter_arbiter.sv
// Shares one force pipeline between NUM_FILTER filter buffers. A registered
// one-hot read request (sel) is issued round-robin; the selected buffer's
// pair word is captured and presented one cycle later on out_*.
module filter_arbiter
  import filter_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = MD_DATA_WIDTH,
  parameter int NUM_FILTER      = MD_NUM_FILTER,
  parameter int FILTER_ID_WIDTH = MD_FILTER_ID_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_FILTER-1:0]                         pair_available,
  input  logic [NUM_FILTER*MD_FIELDS_PER_PAIR*DATA_WIDTH-1:0] pair_data,
  input  logic                                          force_stall,
  output logic [NUM_FILTER-1:0]                         sel,
  output logic                                          out_valid,
  output logic [DATA_WIDTH-1:0]                         out_r2,
  output logic [DATA_WIDTH-1:0]                         out_dx,
  output logic [DATA_WIDTH-1:0]                         out_dy,
  output logic [DATA_WIDTH-1:0]                         out_dz,
  output logic [FILTER_ID_WIDTH-1:0]                    out_filter_id,
  output logic [31:0]                                   pair_count
);

  localparam int WORD_W = MD_FIELDS_PER_PAIR * DATA_WIDTH;

  logic [FILTER_ID_WIDTH-1:0] last_grant;
  logic [NUM_FILTER-1:0]      eligible;
  logic                       gnt_valid;
  logic [FILTER_ID_WIDTH-1:0] gnt_idx;
  logic                       issue;
  logic [WORD_W-1:0]          rd_word;

  // A buffer read this cycle still shows its old empty flag, so it sits out
  // one decision; this is what makes a lone requester go every other cycle.
  always_comb begin
    eligible = pair_available & ~sel;
    issue    = gnt_valid & ~force_stall;
  end

  rr_select #(
    .NUM_FILTER      (NUM_FILTER),
    .FILTER_ID_WIDTH (FILTER_ID_WIDTH)
  ) u_rr_select (
    .req        (eligible),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Registered read request and round-robin pointer; pointer only moves on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      last_grant <= FILTER_ID_WIDTH'(NUM_FILTER - 1);
    end else if (issue) begin
      sel        <= {{(NUM_FILTER-1){1'b0}}, 1'b1} << gnt_idx;
      last_grant <= gnt_idx;
    end else begin
      sel        <= '0;
    end
  end

  // While sel is high, last_grant names the buffer being read.
  always_comb begin
    rd_word = pair_data[int'(last_grant)*WORD_W +: WORD_W];
  end

  // Capture the read word for any outstanding request, even under stall;
  // otherwise drive zeros so idle cycles are clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_r2        <= '0;
      out_dx        <= '0;
      out_dy        <= '0;
      out_dz        <= '0;
      out_filter_id <= '0;
      pair_count    <= '0;
    end else if (|sel) begin
      out_valid     <= 1'b1;
      out_r2        <= rd_word[field_lsb(FIELD_R2, DATA_WIDTH) +: DATA_WIDTH];
      out_dz        <= rd_word[field_lsb(FIELD_DZ, DATA_WIDTH) +: DATA_WIDTH];
      out_dy        <= rd_word[field_lsb(FIELD_DY, DATA_WIDTH) +: DATA_WIDTH];
      out_dx        <= rd_word[field_lsb(FIELD_DX, DATA_WIDTH) +: DATA_WIDTH];
      out_filter_id <= last_grant;
      if (pair_count != 32'hFFFF_FFFF) begin
        pair_count <= pair_count + 32'd1;
      end
    end else begin
      out_valid     <= 1'b0;
      out_r2        <= '0;
      out_dx        <= '0;
      out_dy        <= '0;
      out_dz        <= '0;
      out_filter_id <= '0;
    end
  end

endmodule

// File: tb/tb_filter_arbiter.sv
// Bench for filter_arbiter: table of {avail, stall, expected sel} steps with a
// scoreboard that expects each issued read to appear on out_* one cycle later.
module tb_filter_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pair_available;
  logic [1023:0] pair_data;
  logic          force_stall;
  logic [7:0]    sel;
  logic          out_valid;
  logic [31:0]   out_r2, out_dx, out_dy, out_dz;
  logic [2:0]    out_filter_id;
  logic [31:0]   pair_count;

  filter_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .pair_available (pair_available),
    .pair_data      (pair_data),
    .force_stall    (force_stall),
    .sel            (sel),
    .out_valid      (out_valid),
    .out_r2         (out_r2),
    .out_dx         (out_dx),
    .out_dy         (out_dy),
    .out_dz         (out_dz),
    .out_filter_id  (out_filter_id),
    .pair_count     (pair_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] avail;
    logic       stall;
    logic [7:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [2:0]   id;
    logic [127:0] word;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_count = 0;

  function automatic logic [127:0] word_of(int i);
    if (i == 1) return {32'h42C80000, 32'h3F800000, 32'h40000000, 32'h40400000};
    return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
            32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)};
  endfunction

  function automatic logic [2:0] onehot_idx(logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic start, input logic [7:0] avail,
                         input logic stall, input logic [7:0] exp_sel);
    vec_t v;
    v.start = start; v.avail = avail; v.stall = stall; v.exp_sel = exp_sel;
    vecs.push_back(v);
  endtask

  // One clock; outputs sampled 1ns after the edge.
  task automatic tick(input logic [7:0] exp_sel, input string tag);
    exp_t e;
    @(posedge clk); #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      exp_count++;
      check($sformatf("%s out_valid", tag), 128'(out_valid), 128'd1);
      check($sformatf("%s out_filter_id", tag), 128'(out_filter_id), 128'(e.id));
      check($sformatf("%s out_word", tag), {out_r2, out_dz, out_dy, out_dx}, e.word);
    end else begin
      check($sformatf("%s out_valid idle", tag), 128'(out_valid), 128'd0);
      check($sformatf("%s out_word idle", tag), {out_r2, out_dz, out_dy, out_dx}, 128'd0);
    end
    check($sformatf("%s pair_count", tag), 128'(pair_count), 128'(exp_count));
    check($sformatf("%s sel", tag), 128'(sel), 128'(exp_sel));
    if (exp_sel != 8'h00) begin
      e.id   = onehot_idx(exp_sel);
      e.word = word_of(int'(e.id));
      sb_q.push_back(e);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    pair_available = 8'h00;
    force_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_count = 0;
    check($sformatf("%s reset sel", tag), 128'(sel), 128'd0);
    check($sformatf("%s reset out_valid", tag), 128'(out_valid), 128'd0);
    check($sformatf("%s reset pair_count", tag), 128'(pair_count), 128'd0);
    check($sformatf("%s reset out", tag),
          {out_r2, out_dz, out_dy, out_dx, 125'd0, out_filter_id}, 256'd0);
  endtask

  initial begin
    rst = 1'b1;
    pair_available = 8'h00;
    force_stall = 1'b0;
    for (int i = 0; i < 8; i++) pair_data[i*128 +: 128] = word_of(i);

    // Single requester: every other cycle.
    add_vec(1'b1, 8'h01, 1'b0, 8'h01);
    add_vec(1'b0, 8'h01, 1'b0, 8'h00);
    add_vec(1'b0, 8'h01, 1'b0, 8'h01);
    add_vec(1'b0, 8'h01, 1'b0, 8'h00);
    add_vec(1'b0, 8'h01, 1'b0, 8'h01);
    add_vec(1'b0, 8'h01, 1'b0, 8'h00);
    // All requesting: full rotation plus wrap.
    add_vec(1'b1, 8'hFF, 1'b0, 8'h01);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h02);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h04);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h08);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h10);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h20);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h40);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h80);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h01);
    add_vec(1'b0, 8'hFF, 1'b0, 8'h02);
    // Filters 2 and 5: after grant to 5 the search wraps back to 2.
    add_vec(1'b1, 8'h24, 1'b0, 8'h04);
    add_vec(1'b0, 8'h24, 1'b0, 8'h20);
    add_vec(1'b0, 8'h24, 1'b0, 8'h04);
    add_vec(1'b0, 8'h24, 1'b0, 8'h20);
    // Stall rises while sel=0x08: read still delivered, no new issue.
    add_vec(1'b1, 8'h08, 1'b0, 8'h08);
    add_vec(1'b0, 8'h08, 1'b1, 8'h00);
    add_vec(1'b0, 8'h08, 1'b1, 8'h00);
    add_vec(1'b0, 8'h08, 1'b1, 8'h00);
    add_vec(1'b0, 8'h08, 1'b0, 8'h08);
    add_vec(1'b0, 8'h08, 1'b0, 8'h00);
    // Mixed pattern with a stall bubble.
    add_vec(1'b1, 8'h81, 1'b0, 8'h01);
    add_vec(1'b0, 8'h81, 1'b0, 8'h80);
    add_vec(1'b0, 8'h81, 1'b1, 8'h00);
    add_vec(1'b0, 8'h81, 1'b0, 8'h01);
    add_vec(1'b0, 8'h81, 1'b0, 8'h80);

    foreach (vecs[k]) begin
      if (vecs[k].start) do_reset($sformatf("v%0d", k));
      pair_available = vecs[k].avail;
      force_stall    = vecs[k].stall;
      tick(vecs[k].exp_sel, $sformatf("v%0d", k));
    end
    pair_available = 8'h00;
    force_stall = 1'b0;
    tick(8'h00, "drain");

    // Exact field routing from filter 1.
    do_reset("data");
    pair_available = 8'h02;
    tick(8'h02, "data0");
    pair_available = 8'h00;
    tick(8'h00, "data1");
    check("data out_r2", 128'(out_r2), 128'h42C80000);
    check("data out_dz", 128'(out_dz), 128'h3F800000);
    check("data out_dy", 128'(out_dy), 128'h40000000);
    check("data out_dx", 128'(out_dx), 128'h40400000);
    check("data out_filter_id", 128'(out_filter_id), 128'd1);

    // Reset with a read in flight: delivery dropped, priority back to lowest index.
    do_reset("midrst");
    pair_available = 8'h10;
    tick(8'h10, "midrst_pre");
    rst = 1'b1;
    pair_available = 8'h16;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_count = 0;
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst pair_count", 128'(pair_count), 128'd0);
    check("midrst sel", 128'(sel), 128'd0);
    tick(8'h02, "midrst_post0");
    tick(8'h04, "midrst_post1");
    tick(8'h10, "midrst_post2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
